// File: rtl/decode_stage_if.sv
// Handshake and micro-op bundle between the instruction register, the
// decode stage and the execution units.
interface decode_stage_if #(
   parameter int WORD_W = 64
);
   // instruction side
   logic              ir_valid;
   logic              ir_ready;
   logic [31:0]       ir;
   // micro-op side
   logic              d_valid;
   logic              d_ready;
   logic [1:0]        d_cu_op;
   logic [1:0]        d_alu_op;
   logic              d_alu_a_imm;
   logic [1:0]        d_bus_op;
   logic [1:0]        d_bus_size;
   logic [1:0]        d_io_op;
   logic              d_illegal;
   logic [3:0]        d_rx;
   logic [3:0]        d_ry;
   logic [3:0]        d_rz;
   logic [WORD_W-1:0] d_imm;
   logic [7:0]        d_imm8;
   logic [23:0]       d_jmp_offset;

   // the decode stage: consumes instructions, produces micro-ops
   modport slave (
      input  ir_valid, ir, d_ready,
      output ir_ready, d_valid, d_cu_op, d_alu_op, d_alu_a_imm, d_bus_op,
             d_bus_size, d_io_op, d_illegal, d_rx, d_ry, d_rz, d_imm,
             d_imm8, d_jmp_offset
   );

   // the environment: supplies instructions, drains micro-ops
   modport master (
      output ir_valid, ir, d_ready,
      input  ir_ready, d_valid, d_cu_op, d_alu_op, d_alu_a_imm, d_bus_op,
             d_bus_size, d_io_op, d_illegal, d_rx, d_ry, d_rz, d_imm,
             d_imm8, d_jmp_offset
   );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: one 32-bit instruction in, one registered
// micro-op out per cycle, valid/ready on both sides. Conditional jumps are
// resolved against zf and held back while flag-writing ALU ops are in flight.
module decode_stage #(
   parameter int WORD_W       = 64,
   parameter bit SIGN_EXT_IMM = 1'b0,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          zf,
   input  logic          zf_wb,
   decode_stage_if.slave bus
);
   localparam int              CNT_W   = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

   localparam logic [1:0] CU_NOP      = 2'd0;
   localparam logic [1:0] CU_HALT_IMM = 2'd1;
   localparam logic [1:0] CU_HALT_REG = 2'd2;
   localparam logic [1:0] CU_REL_JMP  = 2'd3;
   localparam logic [1:0] ALU_NOP     = 2'd0;
   localparam logic [1:0] ALU_ADD     = 2'd1;
   localparam logic [1:0] ALU_SUB     = 2'd2;
   localparam logic [1:0] BUS_NOP     = 2'd0;
   localparam logic [1:0] BUS_FETCH   = 2'd1;
   localparam logic [1:0] BUS_STORE   = 2'd2;
   localparam logic [1:0] IO_NOP      = 2'd0;
   localparam logic [1:0] IO_PUTC_REG = 2'd1;
   localparam logic [1:0] IO_PUTC_IMM = 2'd2;

   typedef struct packed {
      logic [1:0]        cu_op;
      logic [1:0]        alu_op;
      logic              alu_a_imm;
      logic [1:0]        bus_op;
      logic [1:0]        bus_size;
      logic [1:0]        io_op;
      logic              illegal;
      logic [3:0]        rx;
      logic [3:0]        ry;
      logic [3:0]        rz;
      logic [WORD_W-1:0] imm;
      logic [7:0]        imm8;
      logic [23:0]       jmp_offset;
   } uop_t;

   logic [7:0]       opcode_s;
   uop_t             dec_s;
   logic             is_alu_s;
   logic             is_cond_s;
   logic             hazard_s;
   logic             ir_ready_s;
   logic             accept_s;
   logic             alu_fire_s;
   logic             zf_dec_s;

   logic             d_valid_d, d_valid_q;
   uop_t             uop_d, uop_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign opcode_s = bus.ir[31:24];

   // combinational decode of the presented instruction word
   always_comb begin
      dec_s            = '0;
      dec_s.rx         = bus.ir[23:20];
      dec_s.ry         = bus.ir[19:16];
      dec_s.rz         = bus.ir[15:12];
      dec_s.imm8       = bus.ir[23:16];
      dec_s.jmp_offset = bus.ir[23:0];
      if (SIGN_EXT_IMM) begin
         dec_s.imm = {{(WORD_W-16){bus.ir[15]}}, bus.ir[15:0]};
      end else begin
         dec_s.imm = {{(WORD_W-16){1'b0}}, bus.ir[15:0]};
      end
      case (opcode_s)
         8'h00: dec_s.cu_op = CU_NOP;
         8'h01: dec_s.cu_op = CU_HALT_IMM;
         8'h02: dec_s.cu_op = CU_HALT_REG;
         8'h03: dec_s.cu_op = zf ? CU_NOP : CU_REL_JMP;
         8'h04: dec_s.cu_op = zf ? CU_REL_JMP : CU_NOP;
         8'h05: dec_s.cu_op = CU_REL_JMP;
         8'h10: begin
            // load-immediate always takes a zero-extended 20-bit value
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_a_imm = 1'b1;
            dec_s.ry        = 4'd0;
            dec_s.rz        = 4'd0;
            dec_s.imm       = {{(WORD_W-20){1'b0}}, bus.ir[19:0]};
         end
         8'h11: dec_s.alu_op = ALU_ADD;
         8'h12: begin
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_a_imm = 1'b1;
         end
         8'h13: dec_s.alu_op = ALU_SUB;
         8'h14: begin
            dec_s.alu_op    = ALU_SUB;
            dec_s.alu_a_imm = 1'b1;
         end
         8'h20, 8'h21, 8'h22, 8'h23: begin
            dec_s.bus_op   = BUS_FETCH;
            dec_s.bus_size = opcode_s[1:0];
         end
         8'h28, 8'h29, 8'h2A, 8'h2B: begin
            dec_s.bus_op   = BUS_STORE;
            dec_s.bus_size = opcode_s[1:0];
         end
         8'h30: dec_s.io_op = IO_PUTC_REG;
         8'h31: dec_s.io_op = IO_PUTC_IMM;
         default: dec_s.illegal = 1'b1;
      endcase
   end

   // hazard detection and input-side handshake
   always_comb begin
      is_alu_s  = (opcode_s >= 8'h10) && (opcode_s <= 8'h14);
      is_cond_s = (opcode_s == 8'h03) || (opcode_s == 8'h04);
      // a conditional jump must see zf after every earlier ALU op, including
      // one still sitting in the output register
      hazard_s  = (is_cond_s && ((cnt_q != {CNT_W{1'b0}}) ||
                                 (d_valid_q && (uop_q.alu_op != ALU_NOP)))) ||
                  (is_alu_s && (cnt_q == CNT_MAX));
      ir_ready_s = !rst && !flush && !hazard_s && (!d_valid_q || bus.d_ready);
      accept_s   = bus.ir_valid && ir_ready_s;
   end

   // next state of the micro-op output register
   always_comb begin
      d_valid_d = d_valid_q;
      uop_d     = uop_q;
      if (flush) begin
         d_valid_d = 1'b0;
      end else if (accept_s) begin
         d_valid_d = 1'b1;
         uop_d     = dec_s;
      end else if (bus.d_ready) begin
         d_valid_d = 1'b0;
      end else begin
         d_valid_d = d_valid_q;
      end
   end

   // next state of the in-flight ALU op scoreboard
   always_comb begin
      // a transfer in a flush cycle is discarded, so it is not counted
      alu_fire_s = d_valid_q && bus.d_ready && !flush && (uop_q.alu_op != ALU_NOP);
      zf_dec_s   = zf_wb && (cnt_q != {CNT_W{1'b0}});
      if (alu_fire_s && !zf_dec_s) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (zf_dec_s && !alu_fire_s) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid_q <= 1'b0;
         uop_q     <= '0;
         cnt_q     <= '0;
      end else begin
         d_valid_q <= d_valid_d;
         uop_q     <= uop_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.ir_ready     = ir_ready_s;
   assign bus.d_valid      = d_valid_q;
   assign bus.d_cu_op      = uop_q.cu_op;
   assign bus.d_alu_op     = uop_q.alu_op;
   assign bus.d_alu_a_imm  = uop_q.alu_a_imm;
   assign bus.d_bus_op     = uop_q.bus_op;
   assign bus.d_bus_size   = uop_q.bus_size;
   assign bus.d_io_op      = uop_q.io_op;
   assign bus.d_illegal    = uop_q.illegal;
   assign bus.d_rx         = uop_q.rx;
   assign bus.d_ry         = uop_q.ry;
   assign bus.d_rz         = uop_q.rz;
   assign bus.d_imm        = uop_q.imm;
   assign bus.d_imm8       = uop_q.imm8;
   assign bus.d_jmp_offset = uop_q.jmp_offset;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances share all inputs, one with
// zero-extended and one with sign-extended immediates.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic zf = 1'b0;
   logic zf_wb = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   decode_stage_if #(.WORD_W(64)) if0 ();
   decode_stage_if #(.WORD_W(64)) if1 ();

   assign if1.ir_valid = if0.ir_valid;
   assign if1.ir       = if0.ir;
   assign if1.d_ready  = if0.d_ready;

   decode_stage #(.WORD_W(64), .SIGN_EXT_IMM(1'b0), .MAX_INFLIGHT(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .zf(zf), .zf_wb(zf_wb), .bus(if0)
   );

   decode_stage #(.WORD_W(64), .SIGN_EXT_IMM(1'b1), .MAX_INFLIGHT(3)) dut_sx (
      .clk(clk), .rst(rst), .flush(flush), .zf(zf), .zf_wb(zf_wb), .bus(if1)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] word);
      if0.ir       = word;
      if0.ir_valid = 1'b1;
   endtask

   function automatic logic [7:0] ops();
      return {if0.d_cu_op, if0.d_alu_op, if0.d_bus_op, if0.d_io_op};
   endfunction

   // directed stimulus
   initial begin
      if0.ir_valid = 1'b0;
      if0.ir       = 32'h0;
      if0.d_ready  = 1'b0;

      // reset state, ir_ready held low while rst is high
      present(32'h11123000);
      if0.d_ready = 1'b1;
      tick();
      tick();
      chk("rst_ir_ready", {63'd0, if0.ir_ready}, 64'd0);
      chk("rst_d_valid", {63'd0, if0.d_valid}, 64'd0);
      chk("rst_ops", {56'd0, ops()}, 64'd0);
      chk("rst_illegal", {63'd0, if0.d_illegal}, 64'd0);
      chk("rst_fields", {52'd0, if0.d_rx, if0.d_ry, if0.d_rz}, 64'd0);
      chk("rst_imm", if0.d_imm, 64'd0);
      chk("rst_imm8_off", {32'd0, if0.d_imm8, if0.d_jmp_offset}, 64'd0);
      rst = 1'b0;
      #1;

      // basic ADD register form, latency 1
      chk("add_ir_ready", {63'd0, if0.ir_ready}, 64'd1);
      tick();
      chk("add_valid", {63'd0, if0.d_valid}, 64'd1);
      chk("add_ops", {56'd0, ops()}, {56'd0, 8'b00_01_00_00});
      chk("add_regs", {52'd0, if0.d_rx, if0.d_ry, if0.d_rz}, {52'd0, 12'h123});
      chk("add_a_imm", {63'd0, if0.d_alu_a_imm}, 64'd0);
      if0.ir_valid = 1'b0;
      tick();
      chk("add_cnt1", {62'd0, dut.cnt_q}, 64'd1);
      chk("add_drained", {63'd0, if0.d_valid}, 64'd0);
      zf_wb = 1'b1;
      tick();
      zf_wb = 1'b0;
      chk("add_cnt0", {62'd0, dut.cnt_q}, 64'd0);

      // immediate extension in both modes, then ldzwq back-to-back
      present(32'h1200FFFF);
      tick();
      chk("imm_zx", if0.d_imm, 64'h000000000000FFFF);
      chk("imm_sx", if1.d_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("imm_ops", {55'd0, if0.d_alu_a_imm, ops()}, {55'd0, 1'b1, 8'b00_01_00_00});
      present(32'h10AFFFFF);
      tick();
      chk("ldz_zx", if0.d_imm, 64'h00000000000FFFFF);
      chk("ldz_sx", if1.d_imm, 64'h00000000000FFFFF);
      chk("ldz_regs", {52'd0, if0.d_rx, if0.d_ry, if0.d_rz}, {52'd0, 12'hA00});
      chk("ldz_ops", {55'd0, if0.d_alu_a_imm, ops()}, {55'd0, 1'b1, 8'b00_01_00_00});
      if0.ir_valid = 1'b0;
      tick();
      chk("ldz_cnt2", {62'd0, dut.cnt_q}, 64'd2);
      zf_wb = 1'b1;
      tick();
      tick();
      zf_wb = 1'b0;
      chk("ldz_cnt0", {62'd0, dut.cnt_q}, 64'd0);

      // SUB followed by jz: stalls until the zf_wb pulse (zf=1, then zf=0)
      for (int pass = 0; pass < 2; pass++) begin
         present(32'h13456000);
         tick();
         chk("sub_ops", {56'd0, ops()}, {56'd0, 8'b00_10_00_00});
         zf = (pass == 0);
         present(32'h04ABCDEF);
         #1;
         chk("jz_stall_out", {63'd0, if0.ir_ready}, 64'd0);
         tick();
         chk("jz_stall_cnt", {63'd0, if0.ir_ready}, 64'd0);
         chk("jz_no_out", {63'd0, if0.d_valid}, 64'd0);
         zf_wb = 1'b1;
         #1;
         chk("jz_stall_wb", {63'd0, if0.ir_ready}, 64'd0);
         tick();
         zf_wb = 1'b0;
         #1;
         chk("jz_ready", {63'd0, if0.ir_ready}, 64'd1);
         tick();
         chk("jz_valid", {63'd0, if0.d_valid}, 64'd1);
         chk("jz_cu", {62'd0, if0.d_cu_op}, (pass == 0) ? 64'd3 : 64'd0);
         chk("jz_off", {40'd0, if0.d_jmp_offset}, 64'hABCDEF);
         if0.ir_valid = 1'b0;
         tick();
      end

      // jnz with zf=0, unconditional jump and halts back-to-back
      zf = 1'b0;
      present(32'h03000010);
      tick();
      chk("jnz_cu", {62'd0, if0.d_cu_op}, 64'd3);
      zf = 1'b1;
      present(32'h05000020);
      tick();
      chk("jmp_cu", {40'd0, if0.d_cu_op, if0.d_jmp_offset[21:0]}, {40'd0, 2'd3, 22'h20});
      present(32'h012A0000);
      tick();
      chk("halt_imm", {54'd0, if0.d_cu_op, if0.d_imm8}, {54'd0, 2'd1, 8'h2A});
      present(32'h02300000);
      tick();
      chk("halt_reg", {58'd0, if0.d_cu_op, if0.d_rx}, {58'd0, 2'd2, 4'h3});
      if0.ir_valid = 1'b0;
      zf = 1'b0;
      tick();

      // scoreboard fills to 3, then a 4th ALU op stalls
      for (int i = 0; i < 3; i++) begin
         present(32'h11000000);
         tick();
         if0.ir_valid = 1'b0;
         tick();
      end
      chk("sb_cnt3", {62'd0, dut.cnt_q}, 64'd3);
      present(32'h11000000);
      #1;
      chk("sb_full_stall", {63'd0, if0.ir_ready}, 64'd0);
      zf_wb = 1'b1;
      tick();
      zf_wb = 1'b0;
      chk("sb_not_taken", {63'd0, if0.d_valid}, 64'd0);
      chk("sb_ready_again", {63'd0, if0.ir_ready}, 64'd1);
      tick();
      tick();
      chk("sb_cnt3_again", {62'd0, dut.cnt_q}, 64'd3);
      if0.ir_valid = 1'b0;
      zf_wb = 1'b1;
      tick();
      zf_wb = 1'b0;
      chk("sb_wb_and_xfer", {62'd0, dut.cnt_q}, 64'd3);
      present(32'h14000000);
      #1;
      chk("sb_still_full", {63'd0, if0.ir_ready}, 64'd0);
      if0.ir_valid = 1'b0;
      zf_wb = 1'b1;
      repeat (4) tick();
      zf_wb = 1'b0;
      chk("sb_floor0", {62'd0, dut.cnt_q}, 64'd0);

      // back-pressure holds the FETCH, then flush drops it
      if0.d_ready = 1'b0;
      present(32'h23120010);
      tick();
      chk("fetch_ops", {60'd0, if0.d_bus_op, if0.d_bus_size}, {60'd0, 2'd1, 2'd3});
      present(32'h2A340000);
      #1;
      chk("bp_ir_ready", {63'd0, if0.ir_ready}, 64'd0);
      tick();
      chk("bp_hold", {43'd0, if0.d_valid, if0.d_bus_op, if0.d_bus_size, if0.d_imm[15:0]},
          {43'd0, 1'b1, 2'd1, 2'd3, 16'h0010});
      chk("bp_regs", {56'd0, if0.d_rx, if0.d_ry}, {56'd0, 8'h12});
      flush = 1'b1;
      #1;
      chk("flush_ir_ready", {63'd0, if0.ir_ready}, 64'd0);
      tick();
      flush = 1'b0;
      chk("flush_valid", {63'd0, if0.d_valid}, 64'd0);
      if0.d_ready = 1'b1;
      tick();
      chk("store_ops", {56'd0, if0.d_bus_op, if0.d_bus_size, if0.d_rx}, {56'd0, 2'd2, 2'd2, 4'h3});

      // illegal opcode and character output
      present(32'h7F000000);
      tick();
      chk("illegal", {55'd0, if0.d_illegal, ops()}, {55'd0, 1'b1, 8'd0});
      present(32'h31411234);
      tick();
      chk("putc_imm", {46'd0, if0.d_illegal, if0.d_io_op, if0.d_imm8, 7'd0, ops()},
          {46'd0, 1'b0, 2'd2, 8'h41, 7'd0, 8'b00_00_00_10});
      present(32'h30500000);
      tick();
      chk("putc_reg", {58'd0, if0.d_io_op, if0.d_rx}, {58'd0, 2'd1, 4'h5});
      if0.ir_valid = 1'b0;
      tick();

      // reset mid-stall drops the pending micro-op
      if0.d_ready = 1'b0;
      present(32'h14000000);
      tick();
      chk("stall_sub", {61'd0, if0.d_valid, if0.d_alu_op}, {61'd0, 1'b1, 2'd2});
      rst = 1'b1;
      #1;
      chk("rst2_ir_ready", {63'd0, if0.ir_ready}, 64'd0);
      tick();
      rst = 1'b0;
      if0.ir_valid = 1'b0;
      chk("rst2_valid", {61'd0, if0.d_valid, if0.d_alu_op}, 64'd0);
      chk("rst2_cnt", {62'd0, dut.cnt_q}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
